// File: rtl/upc_frame_tx.sv
// upc_frame_tx: serialises a {U,P,C,M} item record as start, 4 data bits, even parity, stop
module upc_frame_tx #(
    parameter int BIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [2:0] upc,
    input  logic       mark,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] frame_count
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [7:0] LAST = 8'(BIT_CYCLES - 1);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n, count_n;
    logic [1:0] idx, idx_n;
    logic [3:0] rec, rec_n;
    logic       tx_n, done_n, last;

    assign last = cnt == LAST;

    // next-state, bit timing and next values of the registered outputs
    always_comb begin
        state_n = state;
        cnt_n   = last ? 8'd0 : cnt + 8'd1;
        idx_n   = idx;
        rec_n   = rec;
        done_n  = 1'b0;
        count_n = frame_count;
        case (state)
            IDLE: begin
                cnt_n = 8'd0;
                if (in_valid && in_ready) begin
                    state_n = START;
                    rec_n   = {upc, mark};
                end
            end
            START:  if (last) state_n = DATA;
            DATA: begin
                if (last) begin
                    idx_n = idx + 2'd1;
                    if (idx == 2'd3) state_n = PARITY;
                end
            end
            PARITY: if (last) state_n = STOP;
            STOP: begin
                if (last) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    count_n = frame_count + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        tx_n = (state_n == START)  ? 1'b0 :
               (state_n == DATA)   ? rec_n[~idx_n] :
               (state_n == PARITY) ? ^rec_n : 1'b1;
    end

    // state and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            idx         <= 2'd0;
            rec         <= 4'd0;
            tx          <= 1'b1;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            rec         <= rec_n;
            tx          <= tx_n;
            in_ready    <= state_n == IDLE;
            busy        <= state_n != IDLE;
            frame_done  <= done_n;
            frame_count <= count_n;
        end
    end
endmodule

// File: tb/tb_upc_frame_tx.sv
// tb_upc_frame_tx: directed checks of upc_frame_tx at BIT_CYCLES=4 and BIT_CYCLES=2
module tb_upc_frame_tx;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid, mark, in_ready, tx, busy, frame_done;
    logic [2:0] upc;
    logic [7:0] frame_count;
    logic       in_valid2, mark2, in_ready2, tx2, busy2, frame_done2;
    logic [2:0] upc2;
    logic [7:0] frame_count2;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] cnt_model = 8'd0;

    typedef struct {
        logic [2:0] u;
        logic       m;
        logic [6:0] bits;
    } vec_t;
    vec_t tbl[6];

    upc_frame_tx #(.BIT_CYCLES(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .upc(upc), .mark(mark),
        .in_ready(in_ready), .tx(tx), .busy(busy), .frame_done(frame_done),
        .frame_count(frame_count)
    );

    upc_frame_tx #(.BIT_CYCLES(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid2), .upc(upc2), .mark(mark2),
        .in_ready(in_ready2), .tx(tx2), .busy(busy2), .frame_done(frame_done2),
        .frame_count(frame_count2)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // called in cycle 1 after an accept edge; ends in the frame_done cycle
    task automatic frame4(input logic [6:0] exp, input logic [7:0] cnt_exp,
                          input logic [3:0] junk, input logic [3:0] nxt);
        for (int i = 0; i < 28; i++) begin
            chk($sformatf("tx4_c%0d", i + 1), tx, exp[6 - i / 4]);
            chk("busy4", busy, 1'b1);
            chk("done4_early", frame_done, 1'b0);
            if (i == 4) {upc, mark} = junk;
            step();
        end
        chk("done4", frame_done, 1'b1);
        chk("tx4_idle", tx, 1'b1);
        chk("ready4", in_ready, 1'b1);
        chk("count4", frame_count, cnt_exp);
        {upc, mark} = nxt;
    endtask

    initial begin
        tbl[0] = '{3'b101, 1'b0, 7'b0101001};
        tbl[1] = '{3'b011, 1'b1, 7'b0011111};
        tbl[2] = '{3'b000, 1'b0, 7'b0000001};
        tbl[3] = '{3'b111, 1'b1, 7'b0111101};
        tbl[4] = '{3'b110, 1'b0, 7'b0110001};
        tbl[5] = '{3'b001, 1'b0, 7'b0001011};

        reset_n = 1'b0;
        in_valid = 1'b0; upc = 3'b000; mark = 1'b0;
        in_valid2 = 1'b0; upc2 = 3'b000; mark2 = 1'b0;
        repeat (3) step();
        chk("rst_tx", tx, 1'b1);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_count", frame_count, 8'd0);

        // reset at cycle 10 of a frame aborts it
        reset_n = 1'b1;
        in_valid = 1'b1; {upc, mark} = 4'b1010;
        step();
        in_valid = 1'b0;
        chk("abort_start_tx", tx, 1'b0);
        chk("abort_start_busy", busy, 1'b1);
        repeat (9) step();
        reset_n = 1'b0;
        in_valid = 1'b1; {upc, mark} = 4'b0111;
        step();
        chk("abort_tx", tx, 1'b1);
        chk("abort_ready", in_ready, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", frame_done, 1'b0);
        chk("abort_count", frame_count, 8'd0);

        // first edge with reset released accepts the pending record
        reset_n = 1'b1;
        step();
        in_valid = 1'b0;
        cnt_model++;
        frame4(7'b0011111, cnt_model, 4'b0000, 4'b0000);
        step();
        chk("post_done_low", frame_done, 1'b0);

        foreach (tbl[k]) begin
            in_valid = 1'b1; {upc, mark} = {tbl[k].u, tbl[k].m};
            step();
            in_valid = 1'b0;
            cnt_model++;
            frame4(tbl[k].bits, cnt_model, 4'b1111, 4'b0000);
            step();
            chk("tbl_idle_tx", tx, 1'b1);
            chk("tbl_idle_done", frame_done, 1'b0);
        end

        // in_valid held high: second frame accepted in the frame_done cycle
        in_valid = 1'b1; {upc, mark} = 4'b0101;
        step();
        cnt_model++;
        frame4(7'b0010101, cnt_model, 4'b1111, 4'b1000);
        step();
        cnt_model++;
        chk("b2b_start", tx, 1'b0);
        frame4(7'b0100011, cnt_model, 4'b0110, 4'b0000);
        in_valid = 1'b0;
        step();

        // 256 frames bring frame_count around through 0
        begin
            int pulses = 0;
            in_valid = 1'b1; {upc, mark} = 4'b1100;
            for (int n = 0; n < 256; n++) begin
                for (int c = 0; c < 40 && !frame_done; c++) step();
                chk("wrap_done_timeout", frame_done, 1'b1);
                cnt_model++;
                chk("wrap_count", frame_count, cnt_model);
                pulses++;
                if (n == 255) in_valid = 1'b0;
                step();
            end
            chk("wrap_pulses", pulses, 256);
            chk("wrap_idle", in_ready, 1'b1);
        end

        // BIT_CYCLES=2 over every record value
        for (int v = 0; v < 16; v++) begin
            logic [3:0] r;
            logic [6:0] e;
            r = 4'(v);
            e = {1'b0, r, ^r, 1'b1};
            in_valid2 = 1'b1; {upc2, mark2} = r;
            step();
            in_valid2 = 1'b0;
            for (int i = 0; i < 14; i++) begin
                chk($sformatf("tx2_v%0d_c%0d", v, i + 1), tx2, e[6 - i / 2]);
                chk("done2_early", frame_done2, 1'b0);
                step();
            end
            chk("done2", frame_done2, 1'b1);
            chk("count2", frame_count2, 8'(v + 1));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/upc_frame_tx.md
UPC_FRAME_TX -- requirements
Module: upc_frame_tx

Interface
REQ-001 Parameter BIT_CYCLES, default 4, SHALL set the clock cycles per serial bit; legal range 2..255.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  an item record is presented on upc/mark.
REQ-005 upc  input  3  item code {U,P,C}; U=upc[2], P=upc[1], C=upc[0].
REQ-006 mark  input  1  M, the secret-mark-present bit.
REQ-007 in_ready  output  1  the block can accept a record this cycle.
REQ-008 tx  output  1  serial line; idles high.
REQ-009 busy  output  1  a frame is in progress.
REQ-010 frame_done  output  1  single-cycle pulse after each completed frame.
REQ-011 frame_count  output  8  number of frames completed since reset.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY and STOP; all outputs SHALL be registered.
REQ-013 in_ready SHALL be 1 only in IDLE; busy SHALL equal NOT in_ready.
REQ-014 Accept: in_valid=1 and in_ready=1 at an edge SHALL latch {upc,mark} and move IDLE->START.
REQ-015 upc, mark and in_valid SHALL be ignored while busy=1, and changes to them SHALL not alter the frame in flight.
REQ-016 Frame order on tx: start=0, U, P, C, M, parity, stop=1, giving 7 bits.
REQ-017 Each bit SHALL be held for exactly BIT_CYCLES cycles by a bit-period counter that counts 0..BIT_CYCLES-1 and then wraps to 0.
REQ-018 tx SHALL drive the start bit in the first cycle after the accept edge (latency 1).
REQ-019 DATA SHALL use a 2-bit index for 4 bits (U,P,C,M), and SHALL advance to PARITY after M completes.
REQ-020 The parity bit SHALL equal U^P^C^M, giving even parity over the 5 bits from U through parity.
REQ-021 After the last STOP cycle, the FSM SHALL enter IDLE; in that first IDLE cycle, frame_done SHALL be 1 and frame_count SHALL have already incremented.
REQ-022 frame_count SHALL wrap from 255 to 0 without a flag.
REQ-023 Back-to-back: an accept is legal in the same cycle that frame_done=1; the minimum spacing from a start bit to the next start bit is 7*BIT_CYCLES+1 cycles.
REQ-024 tx SHALL be 1 in every IDLE cycle.

Reset
REQ-025 While reset_n=0 at an edge, the next state SHALL be: IDLE, tx=1, in_ready=1, busy=0, frame_done=0, frame_count=0, bit-period counter=0, latched record=0.
REQ-026 Reset mid-frame SHALL abort the frame with no frame_done and no count increment, and tx SHALL be 1 from the next cycle.
REQ-027 An in_valid asserted during reset SHALL be ignored; the first accept is possible on the first edge with reset_n=1.

Verification
REQ-028 BIT_CYCLES=4: accept upc=101, mark=0 -> tx=0,1,0,1,0,0,1, each bit 4 cycles; frame_done 29 cycles after the accept edge; frame_count=1.
REQ-029 Accept upc=011, mark=1 -> data 0,1,1,1; parity=1; total ones among U..parity = 4 (even).
REQ-030 Hold in_valid=1 continuously with changing upc/mark -> frames back-to-back with 1 idle cycle between them; each frame carries the value sampled at its accept edge.
REQ-031 reset_n=0 at cycle 10 of a frame -> tx=1 next cycle; in_ready=1; frame_count unchanged at 0; no frame_done.
REQ-032 Send 256 frames -> frame_count wraps to 0; frame_done pulses 256 times.
REQ-033 BIT_CYCLES=2, all 16 {upc,mark} values -> each frame is 14 cycles and every parity bit is correct.
